mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, issued from the EX stage. It exposes `busy` so the hazard logic can stall a following mul/div/mfhi/mflo in ID. It replaces the single-cycle datapath assumption with variable-latency execution, generalised in data width and multiplier latency.

Parameters:
- DATA_W, 32, operand/HI/LO width; even, >= 8.
- MUL_LAT, 4, multiply latency in cycles from start edge to result edge; >= 1.
- DIV_LAT (localparam), DATA_W+2, fixed divide latency: 1 pre-abs + DATA_W restoring iterations + 1 sign fix.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  issue strobe from EX, sampled on the rising edge.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 = no-op.
- rs_data  in  DATA_W  operand A (dividend / MTHI-MTLO source).
- rt_data  in  DATA_W  operand B (divisor).
- busy  out  1  operation in flight; registered.
- done  out  1  one-cycle pulse in the cycle after HI/LO update from mul/div.
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.

Behaviour:
- Reset: `hi`=0, `lo`=0, `busy`=0, `done`=0, FSM=IDLE, all counters 0.
  - Reset mid-operation aborts the operation; no HI/LO update occurs.
- FSM states: IDLE, MUL, DIV_PRE, DIV_ITER, DIV_FIX.
- IDLE, `start`=1 on edge E0:
  - MULT/MULTU -> MUL: capture operands, load counter with MUL_LAT-1.
  - DIV/DIVU -> DIV_PRE.
  - MTHI: `hi`<=`rs_data` at E0, stay IDLE, `busy` stays 0, no `done`. MTLO likewise for `lo`.
  - op 6/7: ignored.
- `busy`=1 in every non-IDLE state, i.e. from E0 until the result edge.
- `start` while `busy`=1: ignored entirely, including MTHI/MTLO. The pipeline must stall; the bench flags it as a protocol violation.
- MUL:
  - 2*DATA_W product. Signed for MULT, unsigned for MULTU.
  - At edge E0+MUL_LAT: {`hi`,`lo`}<=product, FSM->IDLE, `busy`<=0, `done`<=1 for one cycle.
  - Internal pipelining/iteration is free, but the result must appear exactly at E0+MUL_LAT.
- DIV_PRE: take absolute values (DIVU: pass-through), record quotient/remainder signs, counter<=DATA_W.
- DIV_ITER: one restoring step per cycle, MSB first; after DATA_W steps -> DIV_FIX.
- DIV_FIX: apply signs and write `hi`/`lo`; result edge = E0+DIV_LAT; `done` pulses next cycle.
- Divide semantics:
  - `lo`=quotient truncated toward zero; `hi`=remainder with the sign of the dividend.
  - Divide by zero: `lo`=all ones, `hi`=`rs_data` (both DIV and DIVU); full DIV_LAT latency still taken.
  - DIV of MIN_INT by -1: `lo`=MIN_INT, `hi`=0.
- HI/LO hold their previous values for the whole operation; intermediate state is never visible.
- `done` and `busy` are never both 1. A new `start` is accepted in the same cycle `done`=1.

Decomposition:
- Shared package `mips_pkg`: MDU op encodings (MDU_MULT..MDU_MTLO), FSM state typedef, DIV_LAT helper function.
- One natural sub-module: `mdu_div_core`, the iterative restoring unsigned divider with start/valid and a counter. Sign handling, HI/LO and the FSM stay in the top.

Test Plan:
- DATA_W=32, MUL_LAT=4. MULT rs=0xFFFFFFFD (-3), rt=5 -> `busy` 4 cycles; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1 at E0+4; one `done` pulse.
- MULTU rs=0xFFFFFFFF, rt=2 -> `hi`=0x00000001, `lo`=0xFFFFFFFE.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF at E0+34.
  - DIVU 100/7 -> `lo`=14, `hi`=2.
- DIV rs=0x12345678, rt=0 -> `lo`=0xFFFFFFFF, `hi`=0x12345678 after 34 cycles.
  - DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- MTLO 0xA5A5A5A5 while IDLE -> `lo` updates next edge, `busy`/`done` stay 0.
  - MTHI issued mid-DIV -> `hi` unchanged, division result unaffected.
- Start DIVU 100/7, assert `rst` at cycle 10 -> `hi`=`lo`=0, `busy`=0, no `done`.
  - A new MULT 6*7 right after reset -> `lo`=42, `hi`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the multiply/divide unit: op encodings,
// FSM state encoding and the fixed divide latency.
package mips_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef logic [2:0] mdu_state_t;

    localparam mdu_state_t ST_IDLE     = 3'd0;
    localparam mdu_state_t ST_MUL      = 3'd1;
    localparam mdu_state_t ST_DIV_PRE  = 3'd2;
    localparam mdu_state_t ST_DIV_ITER = 3'd3;
    localparam mdu_state_t ST_DIV_FIX  = 3'd4;

    // One cycle to take absolute values, one per quotient bit, one to fix signs.
    function automatic int mdu_div_lat(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative restoring unsigned divider: loads on start_i, then produces one
// quotient bit per cycle, MSB first, for ITERS cycles.
module mdu_div_core #(
    parameter int DATA_W = 32,
    parameter int ITERS  = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              last_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o
);

    localparam int CW = $clog2(ITERS + 1);

    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Partial remainder shifted left with the next dividend bit brought in.
    logic [DATA_W:0]   trial;
    logic              fits;
    logic [DATA_W-1:0] rem_sub;

    assign trial   = {rem_q, quo_q[DATA_W-1]};
    assign fits    = (trial >= {1'b0, dvs_q});
    // When the subtraction is taken the true difference is below the divisor,
    // so the low DATA_W bits are exact.
    assign rem_sub = trial[DATA_W-1:0] - dvs_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (start_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
            cnt_d = CW'(ITERS);
        end else if (cnt_q != '0) begin
            rem_d = fits ? rem_sub : trial[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], fits};
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the values from before this edge.
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    // High while the final quotient bit is being produced on the coming edge.
    assign last_o      = (cnt_q == CW'(1));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers;
// fixed-latency MULT/MULTU/DIV/DIVU plus single-edge MTHI/MTLO.
module mdu_hilo
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int DIV_LAT = mdu_div_lat(DATA_W);
    localparam int CNT_W   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

    mdu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              mul_signed_q, mul_signed_d;
    logic              div_signed_q, div_signed_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Sign- or zero-extend to the full product width so one unsigned
    // multiplier yields the correct two's-complement product for both ops.
    logic [2*DATA_W-1:0] mul_a_ext, mul_b_ext, product;

    assign mul_a_ext = {{DATA_W{mul_signed_q & a_q[DATA_W-1]}}, a_q};
    assign mul_b_ext = {{DATA_W{mul_signed_q & b_q[DATA_W-1]}}, b_q};
    assign product   = mul_a_ext * mul_b_ext;

    logic              a_neg, b_neg;
    logic [DATA_W-1:0] div_dividend, div_divisor;
    logic              div_start, div_last;
    logic [DATA_W-1:0] div_quo, div_rem;

    assign a_neg        = div_signed_q & a_q[DATA_W-1];
    assign b_neg        = div_signed_q & b_q[DATA_W-1];
    assign div_dividend = a_neg ? -a_q : a_q;
    assign div_divisor  = b_neg ? -b_q : b_q;

    mdu_div_core #(
        .DATA_W (DATA_W),
        .ITERS  (DIV_LAT - 2)
    ) u_div_core (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start),
        .dividend_i  (div_dividend),
        .divisor_i   (div_divisor),
        .last_o      (div_last),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        mul_signed_d = mul_signed_q;
        div_signed_d = div_signed_q;
        q_neg_d      = q_neg_q;
        r_neg_d      = r_neg_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        done_d       = 1'b0;
        div_start    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            a_d          = rs_data;
                            b_d          = rt_data;
                            mul_signed_d = (op == MDU_MULT);
                            cnt_d        = MUL_LOAD;
                            state_d      = ST_MUL;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            a_d          = rs_data;
                            b_d          = rt_data;
                            div_signed_d = (op == MDU_DIV);
                            state_d      = ST_DIV_PRE;
                        end
                        MDU_MTHI: hi_d = rs_data;
                        MDU_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = product;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DIV_PRE: begin
                div_start = 1'b1;
                q_neg_d   = a_neg ^ b_neg;
                r_neg_d   = a_neg;
                state_d   = ST_DIV_ITER;
            end
            ST_DIV_ITER: begin
                if (div_last) state_d = ST_DIV_FIX;
            end
            ST_DIV_FIX: begin
                // Divide by zero bypasses the sign fix: all-ones quotient and
                // the untouched dividend as remainder, for DIV and DIVU alike.
                if (b_q == '0) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = q_neg_q ? -div_quo : div_quo;
                    hi_d = r_neg_q ? -div_rem : div_rem;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            mul_signed_q <= 1'b0;
            div_signed_q <= 1'b0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mul_signed_q <= mul_signed_d;
            div_signed_q <= div_signed_d;
            q_neg_q      <= q_neg_d;
            r_neg_q      <= r_neg_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed vector table, corner-case
// sequences and random ops against an arithmetic reference model.
module tb_mdu_hilo;

    localparam int W     = 32;
    localparam int MUL_L = 4;
    localparam int DIV_L = 34;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clk = ~clk;

    mdu_hilo #(.DATA_W(W), .MUL_LAT(MUL_L)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    int checks   = 0;
    int failures = 0;

    // Architectural HI/LO as the bench believes them to be.
    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural rules.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eh, output logic [W-1:0] el);
        longint          sp;
        longint unsigned up;
        int              si, sj;
        eh = hi_m;
        el = lo_m;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {eh, el} = sp;
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                {eh, el} = up;
            end
            3'd2: begin
                if (b == 0) begin
                    el = '1; eh = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = a; eh = '0;
                end else begin
                    si = $signed(a);
                    sj = $signed(b);
                    el = si / sj;
                    eh = si % sj;
                end
            end
            3'd3: begin
                if (b == 0) begin
                    el = '1; eh = a;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
            3'd4: eh = a;
            3'd5: el = a;
            default: ;
        endcase
    endtask

    // Issues one op, follows it to completion with a bounded wait, and checks
    // latency, HI/LO hold, final values and the busy/done handshake.
    // poke_at >= 0 fires an MTHI that many cycles into the operation.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          input string nm, input int poke_at);
        int   lat_exp;
        int   n;
        logic held;
        logic overlap;
        lat_exp = (o <= 3'd1) ? MUL_L : (o <= 3'd3) ? DIV_L : 0;
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 3'd7;
        rs_data = $urandom;
        rt_data = $urandom;
        check({nm, "/done_e0"}, {63'd0, done}, 64'd0);
        if (lat_exp == 0) begin
            check({nm, "/hi"}, {32'd0, hi}, {32'd0, eh});
            check({nm, "/lo"}, {32'd0, lo}, {32'd0, el});
            check({nm, "/busy"}, {63'd0, busy}, 64'd0);
        end else begin
            check({nm, "/busy_e0"}, {63'd0, busy}, 64'd1);
            n       = 0;
            held    = 1'b1;
            overlap = 1'b0;
            while (n < 200) begin
                if (n == poke_at) begin
                    start   = 1'b1;
                    op      = 3'd4;
                    rs_data = 32'hDEAD_BEEF;
                end
                @(posedge clk);
                #1;
                start = 1'b0;
                n++;
                if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
                if (done === 1'b1) break;
                if (hi !== hi_m || lo !== lo_m) held = 1'b0;
            end
            check({nm, "/latency"}, 64'(n), 64'(lat_exp));
            check({nm, "/hilo_held"}, {63'd0, held}, 64'd1);
            check({nm, "/busy_done_overlap"}, {63'd0, overlap}, 64'd0);
            check({nm, "/hi"}, {32'd0, hi}, {32'd0, eh});
            check({nm, "/lo"}, {32'd0, lo}, {32'd0, el});
            check({nm, "/busy_end"}, {63'd0, busy}, 64'd0);
        end
        hi_m = eh;
        lo_m = el;
    endtask

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra, rb, reh, rel;
        int           dc;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[4]  = '{3'd2, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        vecs[5]  = '{3'd3, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
        vecs[6]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[7]  = '{3'd5, 32'hA5A5_A5A5, 32'h1111_1111, 32'h0000_0000, 32'hA5A5_A5A5};
        vecs[8]  = '{3'd4, 32'h0BAD_F00D, 32'h2222_2222, 32'h0BAD_F00D, 32'hA5A5_A5A5};
        vecs[9]  = '{3'd6, 32'h3333_3333, 32'h4444_4444, 32'h0BAD_F00D, 32'hA5A5_A5A5};
        vecs[10] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[11] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[12] = '{3'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};
        vecs[13] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};

        rst     = 1'b1;
        start   = 1'b0;
        op      = 3'd0;
        rs_data = '0;
        rt_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/hi", {32'd0, hi}, 64'd0);
        check("reset/lo", {32'd0, lo}, 64'd0);
        check("reset/busy", {63'd0, busy}, 64'd0);
        check("reset/done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                   $sformatf("vec%0d", i), -1);

        // MTHI arriving mid-divide must be dropped without disturbing the result.
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
               "mthi_mid_div", 5);

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) rb = '0;
            else if ($urandom_range(0, 5) == 0) rb = 32'($urandom_range(1, 9));
            model(ro, ra, rb, reh, rel);
            run_op(ro, ra, rb, reh, rel, $sformatf("rand%0d_op%0d", i, ro), -1);
        end

        // Reset in the middle of a divide aborts it with no HI/LO write and no done.
        @(negedge clk);
        start   = 1'b1;
        op      = 3'd3;
        rs_data = 32'd100;
        rt_data = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst/hi", {32'd0, hi}, 64'd0);
        check("midrst/lo", {32'd0, lo}, 64'd0);
        check("midrst/busy", {63'd0, busy}, 64'd0);
        check("midrst/done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dc  = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dc++;
        end
        check("midrst/no_done", 64'(dc), 64'd0);
        check("midrst/lo_after", {32'd0, lo}, 64'd0);
        hi_m = '0;
        lo_m = '0;

        run_op(3'd0, 32'd6, 32'd7, 32'd0, 32'd42, "mult_after_rst", -1);

        @(posedge clk);
        #1;
        check("final/done_low", {63'd0, done}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
